// File: rtl/tiny_cpu_sequencer.sv
// Instruction feeder for TinyCpu: replays a loadable program memory onto the
// CPU In bus, presenting each word for HOLD_CYCLES clocks, then reports done.
module tiny_cpu_sequencer #(
  parameter int unsigned INSTR_W     = 12,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [INSTR_W-1:0] IDLE_INSTR = INSTR_W'(12'hF00)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               halt,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [ADDR_W-1:0]    pc_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [LEN_W-1:0]     len, len_n, len_clamped;
  logic [INSTR_W-1:0]   instr_n;
  logic                 valid_n;

  logic [INSTR_W-1:0]   mem [DEPTH];

  // Program memory has no reset so a loaded program survives Rst_n.
  always_ff @(posedge clk) begin
    if (load_en && (state != RUN)) begin
      mem[load_addr] <= load_data;
    end
  end

  assign len_clamped = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      cnt         <= '0;
      len         <= '0;
      instr       <= IDLE_INSTR;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
      len         <= len_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      busy        <= (state_n == RUN);
      done        <= (state_n == DONE);
    end
  end

  // Next-state and next-output logic; halt outranks start and sequencing.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    len_n   = len;
    instr_n = instr;
    valid_n = instr_valid;

    case (state)
      IDLE, DONE: begin
        if (halt) begin
          state_n = IDLE;
          pc_n    = '0;
          cnt_n   = '0;
          instr_n = IDLE_INSTR;
          valid_n = 1'b0;
        end else if (start) begin
          len_n = len_clamped;
          pc_n  = '0;
          cnt_n = '0;
          if (len_clamped == '0) begin
            state_n = DONE;
            instr_n = IDLE_INSTR;
            valid_n = 1'b0;
          end else begin
            state_n = RUN;
            instr_n = mem['0];
            valid_n = 1'b1;
          end
        end
      end

      RUN: begin
        if (halt) begin
          state_n = IDLE;
          pc_n    = '0;
          cnt_n   = '0;
          instr_n = IDLE_INSTR;
          valid_n = 1'b0;
        end else if (cnt < CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_n = cnt + CNT_W'(1);
        end else if ({1'b0, pc} < (len - LEN_W'(1))) begin
          // Next word is read from the incremented address so there is no bubble.
          pc_n    = pc + ADDR_W'(1);
          cnt_n   = '0;
          instr_n = mem[pc + ADDR_W'(1)];
        end else begin
          state_n = DONE;
          cnt_n   = '0;
          instr_n = IDLE_INSTR;
          valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        pc_n    = '0;
        cnt_n   = '0;
        instr_n = IDLE_INSTR;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule
